// File: rtl/watch_ctrl_fsm.sv
// Run/stop/clear/mode controller for the watch datapath: merges debounced buttons with
// UART commands from an FWFT RX FIFO and acknowledges each consumed byte via the TX FIFO.
module watch_ctrl_fsm #(
  parameter int unsigned NUM_MODES        = 2,
  parameter int unsigned CLEAR_CYCLES     = 1,
  parameter logic [7:0]  CMD_RUN          = 8'h72,
  parameter logic [7:0]  CMD_CLEAR        = 8'h63,
  parameter logic [7:0]  CMD_CHANGE       = 8'h6D,
  parameter bit          CASE_INSENSITIVE = 1'b1,
  localparam int unsigned MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_run_stop,
  input  logic              btn_clear,
  input  logic              btn_change,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rd_en,
  input  logic              tx_full,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  output logic              enable,
  output logic              clear,
  output logic [MODE_W-1:0] mode
);

  localparam int unsigned CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [1:0] {StStop, StRun, StClear} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [MODE_W-1:0]  mode_d;
  logic               enable_d, clear_d, tx_wr_d;
  logic [7:0]         tx_data_d;

  logic       btn_any;
  logic [7:0] cmd;
  logic       is_run, is_clr, is_chg;
  logic       ev_run, ev_clr, ev_chg;
  logic       executed;

  assign btn_any = btn_run_stop | btn_clear | btn_change;
  // Buttons take priority; a pending RX byte waits until a button-free cycle.
  assign rd_en   = reset & ~btn_any & ~rx_empty;
  assign cmd     = CASE_INSENSITIVE ? (rx_data | 8'h20) : rx_data;
  assign is_run  = (cmd == CMD_RUN);
  assign is_clr  = (cmd == CMD_CLEAR);
  assign is_chg  = (cmd == CMD_CHANGE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StStop;
      clr_cnt_q <= '0;
      mode      <= '0;
      enable    <= 1'b0;
      clear     <= 1'b0;
      tx_wr     <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      mode      <= mode_d;
      enable    <= enable_d;
      clear     <= clear_d;
      tx_wr     <= tx_wr_d;
      tx_data   <= tx_data_d;
    end
  end

  always_comb begin
    ev_run = 1'b0;
    ev_clr = 1'b0;
    ev_chg = 1'b0;
    if (btn_any) begin
      ev_run = btn_run_stop;
      ev_clr = btn_clear & ~btn_run_stop;
      ev_chg = btn_change;
    end else if (rd_en) begin
      ev_run = is_run;
      ev_clr = is_clr;
      ev_chg = is_chg;
    end

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mode_d    = mode;
    unique case (state_q)
      StStop: begin
        if (ev_run) begin
          state_d = StRun;
        end else if (ev_clr) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StRun: begin
        if (ev_run) state_d = StStop;
      end
      StClear: begin
        if (clr_cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d = StStop;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = StStop;
    endcase

    if (ev_chg && (state_q != StClear)) begin
      mode_d = (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + 1'b1;
    end
  end

  always_comb begin
    enable_d  = (state_d == StRun);
    clear_d   = (state_d == StClear);
    executed  = ((is_run | is_chg) & (state_q != StClear)) | (is_clr & (state_q == StStop));
    tx_wr_d   = rd_en & ~tx_full;
    tx_data_d = tx_data;
    if (tx_wr_d) begin
      if (!(is_run | is_clr | is_chg)) begin
        tx_data_d = 8'h3F;
      end else if (executed) begin
        tx_data_d = rx_data;
      end else begin
        tx_data_d = 8'h21;
      end
    end
  end

endmodule

// File: tb/tb_watch_ctrl_fsm.sv
// Randomised and directed bench for watch_ctrl_fsm against a behavioural model.
module tb_watch_ctrl_fsm;

  localparam int unsigned NUM_MODES    = 3;
  localparam int unsigned CLEAR_CYCLES = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run_stop, btn_clear, btn_change;
  logic [7:0] rx_data;
  logic       rx_empty, rd_en, tx_full, tx_wr, enable, clear;
  logic [7:0] tx_data;
  logic [1:0] mode;

  watch_ctrl_fsm #(
    .NUM_MODES   (NUM_MODES),
    .CLEAR_CYCLES(CLEAR_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .btn_change  (btn_change),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rd_en       (rd_en),
    .tx_full     (tx_full),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .enable      (enable),
    .clear       (clear),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: running flag, remaining clear cycles, mode number, last ack
  bit m_run;
  int m_clr_left;
  int m_mode;
  int m_txd;
  bit m_txwr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_clr_left = 0; m_mode = 0; m_txd = 0; m_txwr = 0;
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ":enable"}, 32'(enable), 32'(m_run));
    check_eq({where, ":clear"}, 32'(clear), 32'(m_clr_left > 0));
    check_eq({where, ":mode"}, 32'(mode), 32'(m_mode));
    check_eq({where, ":tx_wr"}, 32'(tx_wr), 32'(m_txwr));
    check_eq({where, ":tx_data"}, 32'(tx_data), 32'(m_txd));
  endtask

  // Called at posedge+1: drive one cycle, check rd_en, step the model, check outputs.
  task automatic drive_cycle(input bit brs, input bit bcl, input bit bch, input bit rxe,
                             input logic [7:0] rxd, input bit txf);
    bit btn, rd, er, ec, em, in_clr, is_r, is_c, is_m, exe;
    logic [7:0] c;
    btn_run_stop = brs; btn_clear = bcl; btn_change = bch;
    rx_empty = rxe; rx_data = rxd; tx_full = txf;
    #2;
    btn = brs | bcl | bch;
    rd  = !btn && !rxe;
    check_eq("rd_en", 32'(rd_en), 32'(rd));
    c = rxd | 8'h20;
    is_r = (c == 8'h72); is_c = (c == 8'h63); is_m = (c == 8'h6D);
    er = 0; ec = 0; em = 0;
    if (btn) begin
      er = brs; ec = bcl && !brs; em = bch;
    end else if (rd) begin
      er = is_r; ec = is_c; em = is_m;
    end
    in_clr = (m_clr_left > 0);
    exe = ((is_r || is_m) && !in_clr) || (is_c && !in_clr && !m_run);
    @(posedge clk);
    m_txwr = rd && !txf;
    if (m_txwr) m_txd = !(is_r || is_c || is_m) ? 8'h3F : (exe ? int'(rxd) : 8'h21);
    if (in_clr) begin
      m_clr_left--;
    end else begin
      if (er) m_run = !m_run;
      else if (ec && !m_run) m_clr_left = CLEAR_CYCLES;
      if (em) m_mode = (m_mode + 1) % NUM_MODES;
    end
    #1;
    check_outputs("cycle");
  endtask

  // Asynchronous reset pulse placed between clock edges, with a byte waiting in RX.
  task automatic do_reset();
    btn_run_stop = 0; btn_clear = 0; btn_change = 0;
    rx_empty = 0; rx_data = 8'h72; tx_full = 0;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    check_eq("reset_rd_en", 32'(rd_en), 32'd0);
    #1;
    reset = 1'b1;
    rx_empty = 1;
  endtask

  logic [7:0] byte_tab [8];

  initial begin
    byte_tab = '{8'h72, 8'h52, 8'h63, 8'h43, 8'h6D, 8'h4D, 8'h78, 8'h21};
    reset = 1'b0;
    btn_run_stop = 0; btn_clear = 0; btn_change = 0;
    rx_empty = 1; rx_data = 8'h00; tx_full = 0;
    model_reset();
    #3;
    check_outputs("por");
    check_eq("por_rd_en", 32'(rd_en), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Buttons: run, stop, clear in STOP, idle through clear, run, clear ignored, changes
    drive_cycle(1, 0, 0, 1, 8'h00, 0);
    drive_cycle(1, 0, 0, 1, 8'h00, 0);
    drive_cycle(0, 1, 0, 1, 8'h00, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 1, 8'h00, 0);
    drive_cycle(1, 0, 0, 1, 8'h00, 0);
    drive_cycle(0, 1, 0, 1, 8'h00, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, 1, 8'h00, 0);
    drive_cycle(1, 0, 0, 1, 8'h00, 0);

    // UART: 'R','x','c' back-to-back, then 'r' to stop
    drive_cycle(0, 0, 0, 0, 8'h52, 0);
    drive_cycle(0, 0, 0, 0, 8'h78, 0);
    drive_cycle(0, 0, 0, 0, 8'h63, 0);
    drive_cycle(0, 0, 0, 0, 8'h72, 0);

    // run_stop+clear buttons with a byte pending, then the deferred pop
    drive_cycle(1, 1, 0, 0, 8'h6D, 0);
    drive_cycle(0, 0, 0, 0, 8'h6D, 0);
    // Ack dropped on full TX; command still executes
    drive_cycle(0, 0, 0, 0, 8'h6D, 1);
    drive_cycle(1, 0, 0, 1, 8'h00, 0);
    drive_cycle(0, 0, 0, 0, 8'h63, 0);
    drive_cycle(0, 0, 0, 1, 8'h00, 0);
    do_reset();
    drive_cycle(0, 0, 0, 1, 8'h00, 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        drive_cycle(0, 0, 0, 1, 8'h00, 0);
      end else begin
        drive_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                    ($urandom_range(0, 4) == 0) ? 8'($urandom) : byte_tab[$urandom_range(0, 7)],
                    $urandom_range(0, 4) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/watch_ctrl_fsm.md
Name: watch_ctrl_fsm

Overview:
Parametrised run/stop/clear/mode controller for the watch datapath. It sits between the button debouncers, the UART RX/TX FIFOs and the time counter/display mux. It merges debounced button pulses with ASCII commands popped from a first-word-fall-through (FWFT) RX FIFO. It drives enable, clear and an N-way mode select, and writes an ack byte to the TX FIFO for every UART command it consumes.

Parameters:
NUM_MODES, 2, number of display/count modes; mode wraps from NUM_MODES-1 to 0 (minimum 2)
CLEAR_CYCLES, 1, number of cycles the clear output is held high per clear event (minimum 1)
CMD_RUN, 8'h72, ASCII run/stop toggle command ('r')
CMD_CLEAR, 8'h63, ASCII clear command ('c')
CMD_CHANGE, 8'h6D, ASCII mode-advance command ('m')
CASE_INSENSITIVE, 1, when 1, the commands also match their uppercase equivalents (rx_data | 8'h20 is compared)
MODE_W (localparam), max(1, $clog2(NUM_MODES)), width of mode

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_run_stop  in  1  one-cycle debounced pulse
btn_clear  in  1  one-cycle debounced pulse
btn_change  in  1  one-cycle debounced pulse
rx_data  in  8  RX FIFO head byte; valid whenever rx_empty=0 (FWFT)
rx_empty  in  1  RX FIFO empty flag
rd_en  out  1  RX FIFO pop; combinational
tx_full  in  1  TX FIFO full flag
tx_data  out  8  ack byte; registered
tx_wr  out  1  TX FIFO write strobe; one-cycle pulse, registered
enable  out  1  count enable; registered
clear  out  1  counter clear; registered
mode  out  MODE_W  active mode select; registered

Behaviour:
- Reset (reset=0, asynchronous): state=STOP, mode=0, enable=0, clear=0, tx_wr=0, tx_data=8'h00, clear counter=0. rd_en is forced to 0 while reset=0.
- States:
  - STOP: enable=0, clear=0.
  - RUN: enable=1.
  - CLEAR: clear=1, enable=0; held for exactly CLEAR_CYCLES cycles, then STOP.
- Events are sampled on a rising edge. Outputs reflect an event on the following edge, i.e. 1-cycle latency.
- Event sources per cycle:
  - If any btn_* is high, this cycle's event source is the buttons, and rd_en=0 (UART deferred).
  - Otherwise rd_en = ~rx_empty, and the byte on rx_data is decoded as the event in the same cycle.
- Events:
  - run_stop: STOP->RUN, RUN->STOP; ignored in CLEAR.
  - clear: STOP->CLEAR; ignored in RUN and in CLEAR.
  - change: mode <= (mode==NUM_MODES-1) ? 0 : mode+1. Legal in STOP and RUN and does not alter the run state; ignored in CLEAR.
- Simultaneous buttons:
  - btn_run_stop and btn_clear together: only run_stop is applied.
  - btn_change is applied independently alongside either of them.
- UART acks: one ack per popped byte, written in the cycle after the pop (tx_wr=1).
  - Executed command: tx_data = the received byte (echo).
  - Recognised but ignored in the current state: tx_data = 8'h21 '!'.
  - Unrecognised byte: tx_data = 8'h3F '?'; no state change.
  - If tx_full=1 in the pop cycle, the ack is dropped (tx_wr stays 0) and the command still executes.
- Back-to-back non-empty RX pops on consecutive cycles are legal; throughput is 1 byte per cycle.
- Buttons generate no acks.
- Reset asserted mid-CLEAR or mid-RUN aborts immediately to the reset values. An RX byte popped in the cycle of reset assertion is lost without an ack.

Test Plan:
- Reset then btn_run_stop pulse -> enable=1 on the next edge. Second pulse -> enable=0. mode stays 0 throughout.
- CLEAR_CYCLES=3, in STOP pulse btn_clear -> clear high for exactly 3 cycles, enable=0, then STOP. btn_clear while RUN -> no clear.
- NUM_MODES=3, pulse btn_change 4 times -> mode sequence 1,2,0,1. Change during RUN keeps enable=1.
- RX FIFO holding 'R','x','c' back-to-back while in STOP:
  - rd_en high 3 consecutive cycles.
  - enable=1 after 'R'.
  - tx writes 8'h52, 8'h3F, 8'h21 ('c' is ignored in RUN).
- btn_run_stop and btn_clear in the same cycle with rx_empty=0 -> run_stop only applied, rd_en=0 that cycle. The byte is popped the next cycle.
- tx_full=1 while 'm' is popped -> mode increments, tx_wr stays 0. Then assert reset mid-CLEAR -> all outputs return to reset values asynchronously.
